// File: rtl/intt_bu_pipe_pkg.sv
// intt_bu_pipe_pkg: shared NTT/INTT defaults, Barrett constants and datapath typedefs.
package intt_bu_pipe_pkg;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int unsigned VAL_Q_DEF = 8380417;
   localparam int BARRETT_K = 46;
   localparam longint unsigned BARRETT_MU = (64'd1 << BARRETT_K) / 64'(VAL_Q_DEF);
   typedef logic [DATA_WIDTH_DEF-1:0] q_t;
   typedef logic [2*DATA_WIDTH_DEF-1:0] prod_t;
endpackage

// File: rtl/intt_bu_pipe_if.sv
// intt_bu_pipe_if: valid/ready input and output channels of the INTT butterfly.
interface intt_bu_pipe_if import intt_bu_pipe_pkg::*; #(parameter int DATA_WIDTH = DATA_WIDTH_DEF);
   logic                  valid_i, ready_o, valid_o, ready_i, range_err_o;
   logic [DATA_WIDTH-1:0] data1_i, data2_i, w_i, intt_data1_o, intt_data2_o;
   modport slave (input valid_i, data1_i, data2_i, w_i, ready_i,
                  output ready_o, valid_o, intt_data1_o, intt_data2_o, range_err_o);
   modport master (output valid_i, data1_i, data2_i, w_i, ready_i,
                   input ready_o, valid_o, intt_data1_o, intt_data2_o, range_err_o);
endinterface

// File: rtl/intt_bu_pipe_modq_reduce.sv
// modq_reduce: combinational Barrett reduction of a product < Q^2 into [0, Q).
module modq_reduce import intt_bu_pipe_pkg::*; #(
   parameter int DW = DATA_WIDTH_DEF,
   parameter int unsigned Q = VAL_Q_DEF
) (
   input  logic [2*DW-1:0] x_i,
   output logic [DW-1:0]   y_o
);
   localparam int PW = 2*DW;
   localparam logic [63:0] MU = (64'd1 << BARRETT_K) / 64'(Q);
   logic [PW+63:0] t;
   logic [PW-1:0]  qe, r;
   // quotient estimate undershoots by at most one, so r < 2Q
   always_comb begin
      t   = (PW+64)'(x_i) * (PW+64)'(MU);
      qe  = PW'(t >> BARRETT_K);
      r   = x_i - qe * PW'(Q);
      y_o = DW'(r >= PW'(Q) ? r - PW'(Q) : r);
   end
endmodule

// File: rtl/intt_bu_pipe.sv
// intt_bu_pipe: 3-stage Gentleman-Sande INTT butterfly, a'=(a+b) mod Q, b'=((a-b)*w) mod Q.
// Define INTT_HALVE_EN to halve both outputs mod Q in the last stage.
module intt_bu_pipe import intt_bu_pipe_pkg::*; #(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned Val_Q = VAL_Q_DEF
) (
   input logic          clk_i,
   input logic          reset_i,
   intt_bu_pipe_if.slave bus
);
   localparam int DW = DATA_WIDTH;
   localparam logic [DW-1:0] QV = DW'(Val_Q);
   logic            adv, take, bad;
   logic            v1_q, v2_q, v3_q, err_q;
   logic [DW-1:0]   sum_raw, sum_d, diff_d, red, out1_d, out2_d;
   logic [DW-1:0]   sum1_q, diff1_q, w1_q, sum2_q, out1_q, out2_q;
   logic [2*DW-1:0] prod2_q;
   always_comb begin
      adv     = !v3_q | bus.ready_i;
      take    = bus.valid_i & adv;
      bad     = bus.data1_i >= QV | bus.data2_i >= QV | bus.w_i >= QV;
      sum_raw = bus.data1_i + bus.data2_i;
      sum_d   = sum_raw >= QV ? sum_raw - QV : sum_raw;
      diff_d  = bus.data1_i - bus.data2_i + (bus.data1_i < bus.data2_i ? QV : '0);
`ifdef INTT_HALVE_EN
      // x + Q stays below 2^DW because Q < 2^(DW-1)
      out1_d  = sum2_q[0] ? (sum2_q + QV) >> 1 : sum2_q >> 1;
      out2_d  = red[0] ? (red + QV) >> 1 : red >> 1;
`else
      out1_d  = sum2_q;
      out2_d  = red;
`endif
   end
   modq_reduce #(.DW(DW), .Q(Val_Q)) u_red (.x_i(prod2_q), .y_o(red));
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         {v1_q, v2_q, v3_q, err_q} <= '0;
         {sum1_q, diff1_q, w1_q, sum2_q, out1_q, out2_q} <= '0;
         prod2_q <= '0;
      end else begin
         if (adv) begin
            v1_q    <= bus.valid_i;
            sum1_q  <= sum_d;
            diff1_q <= diff_d;
            w1_q    <= bus.w_i;
            v2_q    <= v1_q;
            sum2_q  <= sum1_q;
            prod2_q <= (2*DW)'(diff1_q) * (2*DW)'(w1_q);
            v3_q    <= v2_q;
            out1_q  <= out1_d;
            out2_q  <= out2_d;
         end
         if (take && bad) err_q <= 1'b1;
      end
   end
   assign bus.ready_o      = adv;
   assign bus.valid_o      = v3_q;
   assign bus.intt_data1_o = out1_q;
   assign bus.intt_data2_o = out2_q;
   assign bus.range_err_o  = err_q;
endmodule

// File: tb/tb_intt_bu_pipe.sv
// tb_intt_bu_pipe: directed and randomized-handshake checks of intt_bu_pipe against a % model.
module tb_intt_bu_pipe;
   localparam longint Q = 8380417;
   logic clk = 0, rst = 1;
   int n_chk = 0, n_pass = 0;
   intt_bu_pipe_if #(.DATA_WIDTH(32)) bus ();
   intt_bu_pipe #(.DATA_WIDTH(32), .Val_Q(32'd8380417)) dut (.clk_i(clk), .reset_i(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic longint hv(input longint x);
`ifdef INTT_HALVE_EN
      return x % 2 ? (x + Q) / 2 : x / 2;
`else
      return x;
`endif
   endfunction

   function automatic longint g1(input longint a, input longint b);
      return hv((a + b) % Q);
   endfunction

   function automatic longint g2(input longint a, input longint b, input longint w);
      return hv((((a - b + Q) % Q) * w) % Q);
   endfunction

   task automatic run(input string tag, input longint a, input longint b, input longint w,
                      input longint e1, input longint e2);
      int n;
      @(negedge clk);
      bus.valid_i = 1; bus.ready_i = 1;
      bus.data1_i = 32'(a); bus.data2_i = 32'(b); bus.w_i = 32'(w);
      @(negedge clk);
      bus.valid_i = 0;
      n = 1;
      while (!bus.valid_o && n < 10) begin @(negedge clk); n++; end
      chk({tag, "_lat"}, n, 3);
      chk({tag, "_a"}, bus.intt_data1_o, e1);
      chk({tag, "_b"}, bus.intt_data2_o, e2);
   endtask

   initial begin
      longint ra[100], rb[100], rw[100], qa[$], qb[$];
      longint h1, h2;
      int idx, got, cyc, n;
      logic hold;
      bus.valid_i = 0; bus.ready_i = 1;
      bus.data1_i = 0; bus.data2_i = 0; bus.w_i = 0;
      repeat (3) @(negedge clk);
      rst = 0;
      #1;
      chk("rst_valid", bus.valid_o, 0);
      chk("rst_d1", bus.intt_data1_o, 0);
      chk("rst_d2", bus.intt_data2_o, 0);
      chk("rst_err", bus.range_err_o, 0);
      chk("rst_ready", bus.ready_o, 1);
`ifdef INTT_HALVE_EN
      run("v532", 5, 3, 2, 4, 2);
      run("v351", 3, 5, 1, 4, 8380416);
      run("wrap", 8380416, 1, 1, 0, 8380416);
      run("qm1sq", 8380416, 0, 8380416, 4190208, 4190209);
      run("v301", 3, 0, 1, 4190210, 4190210);
`else
      run("v532", 5, 3, 2, 8, 4);
      run("v351", 3, 5, 1, 8, 8380415);
      run("wrap", 8380416, 1, 1, 0, 8380415);
      run("qm1sq", 8380416, 0, 8380416, 8380416, 1);
      run("v301", 3, 0, 1, 3, 3);
`endif
      for (int i = 0; i < 100; i++) begin
         ra[i] = $urandom_range(0, 8380416);
         rb[i] = $urandom_range(0, 8380416);
         rw[i] = $urandom_range(0, 8380416);
      end
      idx = 0; got = 0; cyc = 0; hold = 0; h1 = 0; h2 = 0;
      while (got < 100 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (hold) begin
            chk("hold_v", bus.valid_o, 1);
            chk("hold_d1", bus.intt_data1_o, h1);
            chk("hold_d2", bus.intt_data2_o, h2);
         end
         bus.ready_i = 1'($urandom_range(0, 1));
         bus.valid_i = idx < 100;
         if (idx < 100) begin
            bus.data1_i = 32'(ra[idx]); bus.data2_i = 32'(rb[idx]); bus.w_i = 32'(rw[idx]);
         end
         #1;
         chk("rdy", bus.ready_o, !bus.valid_o || bus.ready_i);
         hold = bus.valid_o & !bus.ready_i;
         h1 = bus.intt_data1_o; h2 = bus.intt_data2_o;
         if (bus.valid_o && bus.ready_i) begin
            if (qa.size() == 0) chk("spurious", 1, 0);
            else begin
               chk("rand_d1", bus.intt_data1_o, qa.pop_front());
               chk("rand_d2", bus.intt_data2_o, qb.pop_front());
            end
            got++;
         end
         if (bus.valid_i && bus.ready_o) begin
            qa.push_back(g1(ra[idx], rb[idx]));
            qb.push_back(g2(ra[idx], rb[idx], rw[idx]));
            idx++;
         end
      end
      chk("rand_cnt", got, 100);
      chk("rand_err", bus.range_err_o, 0);
      @(negedge clk);
      bus.valid_i = 0; bus.ready_i = 1;
      repeat (5) @(negedge clk);
      bus.valid_i = 1; bus.data1_i = 1; bus.data2_i = 2; bus.w_i = 32'(Q);
      @(negedge clk);
      bus.valid_i = 0;
      #1;
      chk("err_set", bus.range_err_o, 1);
      repeat (5) @(negedge clk);
      run("post_err", 5, 3, 2, g1(5, 3), g2(5, 3, 2));
      chk("err_sticky", bus.range_err_o, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.valid_i = 1; bus.data1_i = 32'(10 + i); bus.data2_i = 1; bus.w_i = 1;
      end
      @(negedge clk);
      bus.valid_i = 0;
      #1;
      chk("inflight_v", bus.valid_o, 1);
      rst = 1;
      #1;
      chk("flush_v", bus.valid_o, 0);
      chk("flush_d1", bus.intt_data1_o, 0);
      chk("flush_d2", bus.intt_data2_o, 0);
      chk("flush_err", bus.range_err_o, 0);
      @(negedge clk);
      rst = 0;
      n = 0;
      repeat (6) begin @(negedge clk); if (bus.valid_o) n++; end
      chk("flush_none", n, 0);
      run("post_rst", 7, 9, 3, g1(7, 9), g2(7, 9, 3));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
